// File: rtl/soc_system_mm_host.sv
// soc_system_mm_host
// Avalon-MM host: turns one command from a valid/ready command port into one
// chipselect/write_n/read_n bus transfer and returns one response per command.
// It handles waitrequest stalls, a fixed slave read latency and a stuck-bus timeout.
//
// Ports
//   i_clk, i_reset            system clock, asynchronous active-high reset
//   i_cmd_*, o_cmd_ready      command port (write flag, word address, write data)
//   o_rsp_*, i_rsp_ready      response port (read data, timeout error)
//   o_avm_*, i_avm_*          Avalon-MM host side
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | cmd_ready high, waiting for a command
// S_ACCESS | bus strobes driven, waiting for waitrequest low or timeout
// S_LAT    | read accepted, counting slave read latency
// S_RESP   | response presented, waiting for rsp_ready
module soc_system_mm_host #(
   parameter int ADDR_W       = 2,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 0,
   parameter int TIMEOUT      = 255
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_cmd_valid,
   output logic              o_cmd_ready,
   input  logic              i_cmd_write,
   input  logic [ADDR_W-1:0] i_cmd_address,
   input  logic [DATA_W-1:0] i_cmd_writedata,
   output logic              o_rsp_valid,
   input  logic              i_rsp_ready,
   output logic [DATA_W-1:0] o_rsp_readdata,
   output logic              o_rsp_error,
   output logic [ADDR_W-1:0] o_avm_address,
   output logic              o_avm_chipselect,
   output logic              o_avm_write_n,
   output logic              o_avm_read_n,
   output logic [DATA_W-1:0] o_avm_writedata,
   input  logic [DATA_W-1:0] i_avm_readdata,
   input  logic              i_avm_waitrequest
);

   typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_LAT, S_RESP} state_t;

   localparam logic [2:0]  RL3  = 3'(READ_LATENCY);
   localparam logic [15:0] TO16 = 16'(TIMEOUT);

   state_t              r_state,        w_state_nxt;
   logic                r_cmd_ready,    w_cmd_ready_nxt;
   logic                r_rsp_valid,    w_rsp_valid_nxt;
   logic [DATA_W-1:0]   r_rsp_readdata, w_rsp_readdata_nxt;
   logic                r_rsp_error,    w_rsp_error_nxt;
   logic [ADDR_W-1:0]   r_addr,         w_addr_nxt;
   logic                r_cs,           w_cs_nxt;
   logic                r_write_n,      w_write_n_nxt;
   logic                r_read_n,       w_read_n_nxt;
   logic [DATA_W-1:0]   r_wdata,        w_wdata_nxt;
   logic [15:0]         r_wait_cnt,     w_wait_cnt_nxt;
   logic [2:0]          r_lat_cnt,      w_lat_cnt_nxt;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state        <= S_IDLE;
         r_cmd_ready    <= 1'b0;
         r_rsp_valid    <= 1'b0;
         r_rsp_readdata <= '0;
         r_rsp_error    <= 1'b0;
         r_addr         <= '0;
         r_cs           <= 1'b0;
         r_write_n      <= 1'b1;
         r_read_n       <= 1'b1;
         r_wdata        <= '0;
         r_wait_cnt     <= '0;
         r_lat_cnt      <= '0;
      end else begin
         r_state        <= w_state_nxt;
         r_cmd_ready    <= w_cmd_ready_nxt;
         r_rsp_valid    <= w_rsp_valid_nxt;
         r_rsp_readdata <= w_rsp_readdata_nxt;
         r_rsp_error    <= w_rsp_error_nxt;
         r_addr         <= w_addr_nxt;
         r_cs           <= w_cs_nxt;
         r_write_n      <= w_write_n_nxt;
         r_read_n       <= w_read_n_nxt;
         r_wdata        <= w_wdata_nxt;
         r_wait_cnt     <= w_wait_cnt_nxt;
         r_lat_cnt      <= w_lat_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt        = r_state;
      w_cmd_ready_nxt    = r_cmd_ready;
      w_rsp_valid_nxt    = r_rsp_valid;
      w_rsp_readdata_nxt = r_rsp_readdata;
      w_rsp_error_nxt    = r_rsp_error;
      w_addr_nxt         = r_addr;
      w_cs_nxt           = r_cs;
      w_write_n_nxt      = r_write_n;
      w_read_n_nxt       = r_read_n;
      w_wdata_nxt        = r_wdata;
      w_wait_cnt_nxt     = r_wait_cnt;
      w_lat_cnt_nxt      = r_lat_cnt;
      case (r_state)
         S_IDLE: begin
            w_cmd_ready_nxt = 1'b1;
            if (i_cmd_valid && r_cmd_ready) begin
               // the bus registers double as the latched command
               w_cmd_ready_nxt = 1'b0;
               w_cs_nxt        = 1'b1;
               w_write_n_nxt   = ~i_cmd_write;
               w_read_n_nxt    = i_cmd_write;
               w_addr_nxt      = i_cmd_address;
               w_wdata_nxt     = i_cmd_writedata;
               w_wait_cnt_nxt  = '0;
               w_state_nxt     = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (!i_avm_waitrequest) begin
               w_cs_nxt      = 1'b0;
               w_write_n_nxt = 1'b1;
               w_read_n_nxt  = 1'b1;
               if (!r_write_n) begin
                  w_rsp_readdata_nxt = '0;
                  w_rsp_error_nxt    = 1'b0;
                  w_rsp_valid_nxt    = 1'b1;
                  w_state_nxt        = S_RESP;
               end else if (READ_LATENCY == 0) begin
                  w_rsp_readdata_nxt = i_avm_readdata;
                  w_rsp_error_nxt    = 1'b0;
                  w_rsp_valid_nxt    = 1'b1;
                  w_state_nxt        = S_RESP;
               end else begin
                  w_lat_cnt_nxt = 3'd1;
                  w_state_nxt   = S_LAT;
               end
            end else if ((TIMEOUT != 0) && (r_wait_cnt == TO16)) begin
               // counter already holds TIMEOUT stalled edges: this is one past it
               w_cs_nxt           = 1'b0;
               w_write_n_nxt      = 1'b1;
               w_read_n_nxt       = 1'b1;
               w_rsp_readdata_nxt = '0;
               w_rsp_error_nxt    = 1'b1;
               w_rsp_valid_nxt    = 1'b1;
               w_state_nxt        = S_RESP;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + 16'd1;
            end
         end
         S_LAT: begin
            if (r_lat_cnt == RL3) begin
               w_rsp_readdata_nxt = i_avm_readdata;
               w_rsp_error_nxt    = 1'b0;
               w_rsp_valid_nxt    = 1'b1;
               w_state_nxt        = S_RESP;
            end else begin
               w_lat_cnt_nxt = r_lat_cnt + 3'd1;
            end
         end
         S_RESP: begin
            if (i_rsp_ready) begin
               // raising cmd_ready here gives the 3-cycle back-to-back rate
               w_rsp_valid_nxt = 1'b0;
               w_cmd_ready_nxt = 1'b1;
               w_state_nxt     = S_IDLE;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign o_cmd_ready      = r_cmd_ready;
   assign o_rsp_valid      = r_rsp_valid;
   assign o_rsp_readdata   = r_rsp_readdata;
   assign o_rsp_error      = r_rsp_error;
   assign o_avm_address    = r_addr;
   assign o_avm_chipselect = r_cs;
   assign o_avm_write_n    = r_write_n;
   assign o_avm_read_n     = r_read_n;
   assign o_avm_writedata  = r_wdata;

endmodule

// File: tb/tb_soc_system_mm_host.sv
// Bench for soc_system_mm_host built with READ_LATENCY=2, TIMEOUT=4.
module tb_soc_system_mm_host;

   localparam int L  = 2;
   localparam int TO = 4;

   logic        i_clk = 1'b0;
   logic        i_reset = 1'b1;
   logic        i_cmd_valid = 1'b0;
   logic        o_cmd_ready;
   logic        i_cmd_write = 1'b0;
   logic [1:0]  i_cmd_address = '0;
   logic [31:0] i_cmd_writedata = '0;
   logic        o_rsp_valid;
   logic        i_rsp_ready = 1'b0;
   logic [31:0] o_rsp_readdata;
   logic        o_rsp_error;
   logic [1:0]  o_avm_address;
   logic        o_avm_chipselect;
   logic        o_avm_write_n;
   logic        o_avm_read_n;
   logic [31:0] o_avm_writedata;
   logic [31:0] i_avm_readdata = '0;
   logic        i_avm_waitrequest = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // observations of the last transaction
   int          obs_t, obs_strobes, obs_rsp_edge, obs_bus_bad, obs_hold_bad;
   logic [31:0] obs_data;
   logic        obs_err, obs_post_valid, obs_post_ready;
   bit          obs_hung;

   // expectations from the reference model
   int          e_strobes, e_edge;
   logic [31:0] e_data;
   logic        e_err;

   soc_system_mm_host #(.ADDR_W(2), .DATA_W(32), .READ_LATENCY(L), .TIMEOUT(TO)) dut (
      .i_clk(i_clk), .i_reset(i_reset),
      .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready), .i_cmd_write(i_cmd_write),
      .i_cmd_address(i_cmd_address), .i_cmd_writedata(i_cmd_writedata),
      .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
      .o_rsp_readdata(o_rsp_readdata), .o_rsp_error(o_rsp_error),
      .o_avm_address(o_avm_address), .o_avm_chipselect(o_avm_chipselect),
      .o_avm_write_n(o_avm_write_n), .o_avm_read_n(o_avm_read_n),
      .o_avm_writedata(o_avm_writedata), .i_avm_readdata(i_avm_readdata),
      .i_avm_waitrequest(i_avm_waitrequest)
   );

   always #5 i_clk = ~i_clk;
   always @(posedge i_clk) cyc <= cyc + 1;

   // Reference model, edges counted from the command-acceptance edge T.
   // nw = number of stalled edges the slave would present.
   function automatic void model(input bit wr, input int nw, input logic [31:0] rd);
      if (TO != 0 && nw > TO) begin
         e_err = 1'b1; e_strobes = TO + 1; e_edge = TO + 1; e_data = '0;
      end else begin
         e_err     = 1'b0;
         e_strobes = nw + 1;
         e_edge    = wr ? nw + 1 : nw + 1 + L;
         e_data    = wr ? 32'h0 : rd;
      end
   endfunction

   // Drives one command and a slave with nwait stalled edges; readdata is only
   // valid on the edge the host should sample it. Starts and ends on a negedge.
   task automatic run_txn(input bit wr, input logic [1:0] addr, input logic [31:0] wd,
                          input int nwait, input logic [31:0] rd, input int hold,
                          input bit keep_valid);
      int jv, sv;
      bit got;
      obs_strobes = 0; obs_rsp_edge = -1; obs_bus_bad = 0; obs_hold_bad = 0;
      obs_data = '0; obs_err = 1'b0; obs_post_valid = 1'b1; obs_post_ready = 1'b0;
      obs_hung = 1'b0;
      i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_address = addr; i_cmd_writedata = wd;
      i_rsp_ready = 1'b0; i_avm_waitrequest = (nwait > 0);
      sv = 0;
      while (!o_cmd_ready && sv < 50) begin @(negedge i_clk); sv++; end
      if (!o_cmd_ready) begin obs_hung = 1'b1; i_cmd_valid = 1'b0; return; end
      obs_t = cyc + 1;
      jv = -1; got = 1'b0;
      for (int j = 0; j < 200; j++) begin
         @(negedge i_clk);
         if (!keep_valid) i_cmd_valid = 1'b0;
         if (o_avm_chipselect && (!o_avm_write_n || !o_avm_read_n)) begin
            obs_strobes++;
            if (o_avm_address !== addr) obs_bus_bad++;
            if (wr && (o_avm_write_n !== 1'b0 || o_avm_read_n !== 1'b1 || o_avm_writedata !== wd))
               obs_bus_bad++;
            if (!wr && (o_avm_read_n !== 1'b0 || o_avm_write_n !== 1'b1)) obs_bus_bad++;
         end
         if (jv < 0 && o_rsp_valid) begin
            jv = j; obs_rsp_edge = j; obs_data = o_rsp_readdata; obs_err = o_rsp_error;
            if (o_cmd_ready) obs_hold_bad++;
         end else if (jv >= 0) begin
            if (j <= jv + hold) begin
               if (!o_rsp_valid || o_rsp_readdata !== obs_data || o_rsp_error !== obs_err || o_cmd_ready)
                  obs_hold_bad++;
            end else begin
               obs_post_valid = o_rsp_valid; obs_post_ready = o_cmd_ready; got = 1'b1;
            end
         end
         i_avm_waitrequest = (j + 1 <= nwait);
         i_avm_readdata = (!wr && (j + 1 == 1 + nwait + L)) ? rd : $urandom;
         i_rsp_ready = (jv >= 0 && j >= jv + hold);
         if (got) break;
      end
      if (!got) obs_hung = 1'b1;
      i_rsp_ready = 1'b0; i_avm_waitrequest = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      n_checks++;
      if ({o_cmd_ready, o_rsp_valid, o_rsp_error, o_avm_chipselect, o_avm_write_n, o_avm_read_n} !== 6'b000011) begin
         n_fail++;
         $display("FAIL reset_ctrl: got %b expected 000011",
                  {o_cmd_ready, o_rsp_valid, o_rsp_error, o_avm_chipselect, o_avm_write_n, o_avm_read_n});
      end
      n_checks++;
      if (o_rsp_readdata !== 32'h0 || o_avm_writedata !== 32'h0 || o_avm_address !== 2'd0) begin
         n_fail++;
         $display("FAIL reset_data: got rdata=%h wdata=%h addr=%0d expected zeros",
                  o_rsp_readdata, o_avm_writedata, o_avm_address);
      end
      i_reset = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if (o_cmd_ready !== 1'b1 || o_rsp_valid !== 1'b0 || o_avm_chipselect !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release: got ready=%b valid=%b cs=%b expected 1 0 0",
                  o_cmd_ready, o_rsp_valid, o_avm_chipselect);
      end
   endtask

   task automatic test_write_basic();
      run_txn(1'b1, 2'd0, 32'h1, 0, 32'h0, 0, 1'b0);
      model(1'b1, 0, 32'h0);
      n_checks++;
      if (obs_hung || obs_strobes !== e_strobes || obs_rsp_edge !== e_edge) begin
         n_fail++;
         $display("FAIL write_timing: got strobes=%0d rsp_edge=%0d hung=%0d expected %0d %0d 0",
                  obs_strobes, obs_rsp_edge, obs_hung, e_strobes, e_edge);
      end
      n_checks++;
      if (obs_data !== e_data || obs_err !== e_err || obs_bus_bad !== 0) begin
         n_fail++;
         $display("FAIL write_data: got rdata=%h err=%b busbad=%0d expected %h %b 0",
                  obs_data, obs_err, obs_bus_bad, e_data, e_err);
      end
   endtask

   task automatic test_read_wait();
      run_txn(1'b0, 2'd2, 32'h0, 3, 32'hA5A5_0001, 0, 1'b0);
      model(1'b0, 3, 32'hA5A5_0001);
      n_checks++;
      if (obs_hung || obs_strobes !== e_strobes || obs_rsp_edge !== e_edge) begin
         n_fail++;
         $display("FAIL read_wait_timing: got strobes=%0d rsp_edge=%0d hung=%0d expected %0d %0d 0",
                  obs_strobes, obs_rsp_edge, obs_hung, e_strobes, e_edge);
      end
      n_checks++;
      if (obs_data !== e_data || obs_err !== e_err || obs_bus_bad !== 0) begin
         n_fail++;
         $display("FAIL read_wait_data: got rdata=%h err=%b busbad=%0d expected %h %b 0",
                  obs_data, obs_err, obs_bus_bad, e_data, e_err);
      end
   endtask

   task automatic test_timeout();
      run_txn(1'b0, 2'd1, 32'h0, 1000, 32'hDEAD_BEEF, 0, 1'b0);
      model(1'b0, 1000, 32'hDEAD_BEEF);
      n_checks++;
      if (obs_hung || obs_strobes !== e_strobes || obs_rsp_edge !== e_edge) begin
         n_fail++;
         $display("FAIL timeout_timing: got strobes=%0d rsp_edge=%0d hung=%0d expected %0d %0d 0",
                  obs_strobes, obs_rsp_edge, obs_hung, e_strobes, e_edge);
      end
      n_checks++;
      if (obs_data !== e_data || obs_err !== e_err) begin
         n_fail++;
         $display("FAIL timeout_rsp: got rdata=%h err=%b expected %h %b", obs_data, obs_err, e_data, e_err);
      end
      run_txn(1'b0, 2'd3, 32'h0, 1, 32'h1234_5678, 0, 1'b0);
      model(1'b0, 1, 32'h1234_5678);
      n_checks++;
      if (obs_hung || obs_rsp_edge !== e_edge || obs_data !== e_data || obs_err !== e_err) begin
         n_fail++;
         $display("FAIL after_timeout: got edge=%0d rdata=%h err=%b expected %0d %h %b",
                  obs_rsp_edge, obs_data, obs_err, e_edge, e_data, e_err);
      end
   endtask

   task automatic test_backpressure();
      int t0, r_edge;
      run_txn(1'b1, 2'd2, 32'hCAFE_0002, 0, 32'h0, 10, 1'b1);
      t0 = obs_t; r_edge = obs_rsp_edge + 10 + 1;
      n_checks++;
      if (obs_hung || obs_hold_bad !== 0 || obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL backpressure_hold: got holdbad=%0d post_valid=%b post_ready=%b hung=%0d expected 0 0 1 0",
                  obs_hold_bad, obs_post_valid, obs_post_ready, obs_hung);
      end
      run_txn(1'b0, 2'd1, 32'h0, 0, 32'h0BAD_F00D, 0, 1'b0);
      model(1'b0, 0, 32'h0BAD_F00D);
      n_checks++;
      if (obs_t - t0 !== r_edge + 1 || obs_data !== e_data || obs_rsp_edge !== e_edge) begin
         n_fail++;
         $display("FAIL backpressure_next: got accept_gap=%0d rdata=%h edge=%0d expected %0d %h %0d",
                  obs_t - t0, obs_data, obs_rsp_edge, r_edge + 1, e_data, e_edge);
      end
   endtask

   task automatic test_back_to_back();
      int prev_t;
      prev_t = -1;
      for (int k = 0; k < 4; k++) begin
         run_txn(1'b1, 2'(k), $urandom, 0, 32'h0, 0, 1'b0);
         if (prev_t >= 0) begin
            n_checks++;
            if (obs_t - prev_t !== 3 || obs_hung) begin
               n_fail++;
               $display("FAIL back_to_back: got cycles_per_cmd=%0d hung=%0d expected 3 0", obs_t - prev_t, obs_hung);
            end
         end
         prev_t = obs_t;
      end
   endtask

   task automatic test_reset_mid();
      int bad;
      i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_address = 2'd3; i_avm_waitrequest = 1'b1;
      while (!o_cmd_ready) @(negedge i_clk);
      @(negedge i_clk);
      i_cmd_valid = 1'b0;
      @(negedge i_clk);
      n_checks++;
      if (o_avm_chipselect !== 1'b1 || o_avm_read_n !== 1'b0) begin
         n_fail++;
         $display("FAIL mid_reset_setup: got cs=%b read_n=%b expected 1 0", o_avm_chipselect, o_avm_read_n);
      end
      #2 i_reset = 1'b1;
      #1;
      n_checks++;
      if (o_avm_chipselect !== 1'b0 || o_avm_write_n !== 1'b1 || o_avm_read_n !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reset_strobes: got cs=%b wn=%b rn=%b expected 0 1 1",
                  o_avm_chipselect, o_avm_write_n, o_avm_read_n);
      end
      i_avm_waitrequest = 1'b0;
      @(negedge i_clk);
      i_reset = 1'b0;
      i_rsp_ready = 1'b0;
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge i_clk);
         if (o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b1 || o_avm_chipselect !== 1'b0) bad++;
      end
      n_checks++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_quiet: got %0d bad cycles expected 0", bad);
      end
      run_txn(1'b1, 2'd1, 32'h5555_AAAA, 2, 32'h0, 1, 1'b0);
      model(1'b1, 2, 32'h0);
      n_checks++;
      if (obs_hung || obs_rsp_edge !== e_edge || obs_strobes !== e_strobes || obs_err !== e_err || obs_bus_bad !== 0) begin
         n_fail++;
         $display("FAIL mid_reset_next: got edge=%0d strobes=%0d err=%b busbad=%0d expected %0d %0d %b 0",
                  obs_rsp_edge, obs_strobes, obs_err, obs_bus_bad, e_edge, e_strobes, e_err);
      end
   endtask

   task automatic test_random();
      bit          wr;
      int          nw, hold;
      logic [31:0] wd, rd;
      logic [1:0]  addr;
      for (int k = 0; k < 25; k++) begin
         wr = 1'($urandom_range(0, 1)); nw = $urandom_range(0, 6); hold = $urandom_range(0, 3);
         wd = $urandom; rd = $urandom; addr = 2'($urandom_range(0, 3));
         run_txn(wr, addr, wd, nw, rd, hold, 1'b0);
         model(wr, nw, rd);
         n_checks++;
         if (obs_hung || obs_strobes !== e_strobes || obs_rsp_edge !== e_edge) begin
            n_fail++;
            $display("FAIL rand_timing[%0d]: got strobes=%0d edge=%0d hung=%0d expected %0d %0d 0 (wr=%0d nw=%0d)",
                     k, obs_strobes, obs_rsp_edge, obs_hung, e_strobes, e_edge, wr, nw);
         end
         n_checks++;
         if (obs_data !== e_data || obs_err !== e_err) begin
            n_fail++;
            $display("FAIL rand_rsp[%0d]: got rdata=%h err=%b expected %h %b", k, obs_data, obs_err, e_data, e_err);
         end
         n_checks++;
         if (obs_bus_bad !== 0 || obs_hold_bad !== 0 || obs_post_valid !== 1'b0 || obs_post_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_handshake[%0d]: got busbad=%0d holdbad=%0d post_valid=%b post_ready=%b expected 0 0 0 1",
                     k, obs_bus_bad, obs_hold_bad, obs_post_valid, obs_post_ready);
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_basic();
      test_read_wait();
      test_timeout();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got time limit reached expected test completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/soc_system_mm_host.md
# soc_system_mm_host

Avalon-MM host (initiator) that turns single commands from a local valid/ready command port into one bus transfer each on a chipselect/write_n/read_n slave interface, such as the system's PIO registers. It handles waitrequest stalls, a fixed slave read latency and a stuck-bus timeout. It returns one response per command. It sits between on-chip control logic (sequencers, test engines) and the memory-mapped register slaves.

## Interface
- ADDR_W, 2: avm_address / cmd_address width
- DATA_W, 32: data width
- READ_LATENCY, 0: slave read latency in cycles after acceptance; legal 0..7
- TIMEOUT, 255: max cycles waitrequest may stay high before abort; 0 disables the timeout; legal 0..65535
- clk  in  1  system clock; everything is synchronous to its rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  host can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_address  in  ADDR_W  target word address
- cmd_writedata  in  DATA_W  write data; ignored for reads
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts the response
- rsp_readdata  out  DATA_W  read data; 0 for writes and on error
- rsp_error  out  1  transfer aborted by timeout
- avm_address  out  ADDR_W  bus address
- avm_chipselect  out  1  bus select
- avm_write_n  out  1  active-low write strobe
- avm_read_n  out  1  active-low read strobe
- avm_writedata  out  DATA_W  bus write data
- avm_readdata  in  DATA_W  bus read data
- avm_waitrequest  in  1  slave stall; tie to 0 for zero-wait slaves

## Operation
- All outputs are registered.
- Reset values: cmd_ready=0, rsp_valid=0, rsp_readdata=0, rsp_error=0, avm_chipselect=0, avm_write_n=1, avm_read_n=1, avm_address=0, avm_writedata=0. State is IDLE.
- State IDLE:
  - cmd_ready=1 (first becomes 1 on the first clk edge after reset deasserts).
  - On cmd_valid & cmd_ready, latch the command, drop cmd_ready and go to ACCESS.
- State ACCESS:
  - Drive avm_chipselect=1, avm_address, avm_writedata, and avm_write_n=0 (write) or avm_read_n=0 (read).
  - Hold all bus signals unchanged while avm_waitrequest=1.
  - The edge with avm_waitrequest=0 is acceptance. Deassert the bus signals on that edge.
  - After acceptance:
    - write → RESP;
    - read with READ_LATENCY=0 → capture avm_readdata at acceptance, go to RESP;
    - read with READ_LATENCY>0 → go to LAT.
  - A wait counter increments on each edge with waitrequest=1. When it reaches TIMEOUT (TIMEOUT≠0): deassert the bus signals, set rsp_error=1 and rsp_readdata=0, go to RESP.
- State LAT:
  - A counter runs from 1 to READ_LATENCY.
  - Capture avm_readdata on the edge where the count equals READ_LATENCY, then go to RESP.
  - avm_waitrequest is ignored in this state.
- State RESP:
  - rsp_valid=1; rsp_readdata and rsp_error are held stable.
  - On rsp_valid & rsp_ready, clear rsp_valid and go to IDLE. rsp_readdata and rsp_error keep their values until the next capture.
- At most one command is outstanding. A new command cannot be accepted in the same cycle as a response handshake.
- For a write, rsp_readdata=0.
- Reset mid-operation: the bus strobes drop immediately (asynchronous). Any latched command or pending response is discarded. No response is ever produced for it.

## Timing
- Let T be the edge where cmd_valid & cmd_ready.
- Bus strobes are valid from T+1.
- Zero-wait write: acceptance at edge T+1; rsp_valid high from T+2.
- Zero-wait read with latency L: readdata sampled at edge T+1+L; rsp_valid high from T+2+L.
- Each waitrequest cycle adds exactly one cycle.
- Timeout with waitrequest stuck high: strobes drop and rsp_valid rises at edge T+1+TIMEOUT.
- Response handshake at edge R: cmd_ready=1 from R+1. Back-to-back zero-wait writes with rsp_ready=1 take 3 cycles per command.

## Test plan
- Reset, then idle: every output matches its reset value. cmd_ready=1 one cycle after reset deasserts.
- Write addr=0, data=0x1, waitrequest=0: one cycle of chipselect=1, write_n=0, address=0, writedata=0x1. Then rsp_valid=1, rsp_error=0, rsp_readdata=0.
- Read with READ_LATENCY=2, waitrequest high for 3 cycles, slave drives 0xA5A5_0001 two cycles after acceptance: read_n stays low 4 cycles, rsp_readdata=0xA5A5_0001, rsp_valid at T+7.
- TIMEOUT=4, waitrequest held at 1: strobes drop and rsp_valid=1 with rsp_error=1, rsp_readdata=0 at T+5. The next command completes normally.
- rsp_ready held low for 10 cycles: rsp_valid and data stay stable, cmd_ready=0 throughout, and a cmd_valid held high is not accepted until the cycle after the handshake.
- Assert reset during ACCESS with waitrequest=1: chipselect=0, write_n=1, read_n=1 immediately. No rsp_valid after release; the next command behaves normally.
